// File: rtl/im_arb_pkg.sv
// Shared types for the three-CPU instruction-memory arbiter: CPU ids and return tags.
package im_arb_pkg;

    localparam int N_CPU = 3;
    localparam int ID_W  = $clog2(N_CPU);

    typedef logic [ID_W-1:0] cpu_id_t;

    typedef struct packed {
        logic    valid;
        cpu_id_t id;
    } tag_t;

endpackage

// File: rtl/im_rr_pick.sv
// Combinational round-robin picker: zero latency, searches last+1, last+2, ..., last.
// No backpressure; the grant is purely a function of this cycle's requests.
module im_rr_pick
    import im_arb_pkg::*;
(
    input  logic [N_CPU-1:0] req,
    input  cpu_id_t          last,
    output logic             gnt_vld,
    output cpu_id_t          gnt_id
);

    cpu_id_t cand;

    // Walk from lowest to highest priority so the nearest successor of last overwrites.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int off = N_CPU; off >= 1; off--) begin
            cand = cpu_id_t'((int'(last) + off) % N_CPU);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

endmodule

// File: rtl/im_rr_arbiter.sv
// Round-robins CPU fetches onto one fixed-latency memory; vld pulses MEM_LAT+1 cycles after issue.
// No backpressure: each CPU has one fetch in flight, blocked by its busy bit until delivery.
module im_rr_arbiter #(
    parameter int N_CPU   = 3,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CPU-1:0]              cpu_en,
    input  logic [N_CPU-1:0][ADDR_W-1:0]  cpu_im_addr,
    output logic [N_CPU-1:0][31:0]        cpu_im_data,
    output logic [N_CPU-1:0]              cpu_im_vld,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [31:0]                   mem_data
);

    import im_arb_pkg::*;

    logic [N_CPU-1:0] busy;
    logic [N_CPU-1:0] elig;
    logic [N_CPU-1:0] gnt_mask;
    cpu_id_t          last;
    cpu_id_t          gnt_id;
    logic             pick_vld;
    logic             gnt_vld;
    tag_t             tag_pipe [MEM_LAT];
    tag_t             new_tag;
    tag_t             tail;

    assign elig = cpu_en & ~busy;

    im_rr_pick u_pick (
        .req     (elig),
        .last    (last),
        .gnt_vld (pick_vld),
        .gnt_id  (gnt_id)
    );

    // Grant is combinational, so hold it off while reset is asserted to keep the memory quiet.
    assign gnt_vld  = pick_vld & rst;
    assign mem_req  = gnt_vld;
    assign mem_addr = gnt_vld ? cpu_im_addr[gnt_id] : '0;
    assign tail     = tag_pipe[MEM_LAT-1];

    always_comb begin
        gnt_mask = '0;
        if (gnt_vld) begin
            gnt_mask[gnt_id] = 1'b1;
        end
        new_tag.valid = gnt_vld;
        new_tag.id    = gnt_id;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            last        <= cpu_id_t'(N_CPU - 1);
            cpu_im_vld  <= '0;
            cpu_im_data <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            // A CPU's busy bit drops at the end of its vld cycle, never earlier.
            busy <= (busy & ~cpu_im_vld) | gnt_mask;
            if (gnt_vld) begin
                last <= gnt_id;
            end
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            cpu_im_vld <= '0;
            if (tail.valid) begin
                cpu_im_vld[tail.id]  <= 1'b1;
                cpu_im_data[tail.id] <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_im_rr_arbiter.sv
// Directed bench for im_rr_arbiter: vector table at MEM_LAT=2 plus reset and fairness sequences.
module tb_im_rr_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [2:0]        en  = '0;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  data;
    logic [2:0]        vld;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data;
    logic [31:0]       md1, md2;

    logic [2:0]        en2 = '0;
    logic [2:0][31:0]  addr2;
    logic [2:0][31:0]  data2;
    logic [2:0]        vld2;
    logic              mem_req2;
    logic [31:0]       mem_addr2;
    logic [31:0]       mem_data2;
    logic [31:0]       m2d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    im_rr_arbiter #(.N_CPU(3), .ADDR_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .cpu_en(en), .cpu_im_addr(addr),
        .cpu_im_data(data), .cpu_im_vld(vld), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    im_rr_arbiter #(.N_CPU(3), .ADDR_W(32), .MEM_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .cpu_en(en2), .cpu_im_addr(addr2),
        .cpu_im_data(data2), .cpu_im_vld(vld2), .mem_req(mem_req2),
        .mem_addr(mem_addr2), .mem_data(mem_data2)
    );

    // Memory models: data = addr ^ K, returned MEM_LAT cycles after issue.
    always @(posedge clk) begin
        md1 <= mem_addr ^ K;
        md2 <= md1;
        m2d <= mem_addr2 ^ K;
    end
    assign mem_data  = md2;
    assign mem_data2 = m2d;

    typedef struct {
        bit          do_rst;
        logic [2:0]  en;
        logic        req;
        logic [31:0] addr;
        logic [2:0]  vld;
        logic [31:0] data;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit r, input logic [2:0] e, input logic q, input logic [31:0] a,
                       input logic [2:0] v, input logic [31:0] d);
        vec_t x;
        x.do_rst = r; x.en = e; x.req = q; x.addr = a; x.vld = v; x.data = d;
        tv.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [2:0] e, input logic [2:0] e2);
        rst = 1'b0;
        en  = e;
        en2 = e2;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    int         cnt [3];
    logic [2:0] mbusy;
    logic [2:0][31:0] prev;
    int         nv;
    int         id;

    initial begin
        addr  = {32'h30, 32'h20, 32'h10};
        addr2 = {32'h300, 32'h200, 32'h100};

        // Round-robin, all enabled.
        add(1, 3'b111, 1, 32'h10, 3'b000, 0);
        add(0, 3'b111, 1, 32'h20, 3'b000, 0);
        add(0, 3'b111, 1, 32'h30, 3'b000, 0);
        add(0, 3'b111, 0, 32'h00, 3'b001, 32'hA5A5_0010);
        add(0, 3'b111, 1, 32'h10, 3'b010, 32'hA5A5_0020);
        add(0, 3'b111, 1, 32'h20, 3'b100, 32'hA5A5_0030);
        add(0, 3'b111, 1, 32'h30, 3'b000, 0);
        add(0, 3'b111, 0, 32'h00, 3'b001, 32'hA5A5_0010);
        // Single CPU1: issue every 4 cycles, vld 3 cycles later.
        for (int c = 0; c < 12; c++) begin
            add(c == 0, 3'b010, (c % 4) == 0, ((c % 4) == 0) ? 32'h20 : 32'h0,
                ((c % 4) == 3) ? 3'b010 : 3'b000, ((c % 4) == 3) ? 32'hA5A5_0020 : 32'h0);
        end
        // CPU2 disabled the cycle after its issue.
        add(1, 3'b111, 1, 32'h10, 3'b000, 0);
        add(0, 3'b111, 1, 32'h20, 3'b000, 0);
        add(0, 3'b111, 1, 32'h30, 3'b000, 0);
        add(0, 3'b011, 0, 32'h00, 3'b001, 32'hA5A5_0010);
        add(0, 3'b011, 1, 32'h10, 3'b010, 32'hA5A5_0020);
        add(0, 3'b011, 1, 32'h20, 3'b100, 32'hA5A5_0030);
        add(0, 3'b011, 0, 32'h00, 3'b000, 0);
        add(0, 3'b011, 0, 32'h00, 3'b001, 32'hA5A5_0010);
        add(0, 3'b011, 1, 32'h10, 3'b010, 32'hA5A5_0020);
        add(0, 3'b011, 1, 32'h20, 3'b000, 0);
        add(0, 3'b011, 0, 32'h00, 3'b000, 0);
        add(0, 3'b011, 0, 32'h00, 3'b001, 32'hA5A5_0010);

        // Reset state before anything runs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_vld", 32'(vld), 32'h0);
        chk("reset_last_data", data[2], 32'h0);

        foreach (tv[i]) begin
            if (tv[i].do_rst) begin
                do_reset(tv[i].en, 3'b000);
            end else begin
                @(posedge clk);
                #1 en = tv[i].en;
            end
            @(negedge clk);
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(tv[i].req));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].addr);
            chk($sformatf("v%0d_vld", i), 32'(vld), 32'(tv[i].vld));
            if (tv[i].vld != 3'b000) begin
                id = tv[i].vld[0] ? 0 : (tv[i].vld[1] ? 1 : 2);
                chk($sformatf("v%0d_data", i), data[id], tv[i].data);
            end
        end

        // Reset while CPU0 and CPU1 are in flight.
        do_reset(3'b111, 3'b000);
        @(negedge clk);
        chk("rmf_c0_addr", mem_addr, 32'h10);
        @(posedge clk);
        @(negedge clk);
        chk("rmf_c1_addr", mem_addr, 32'h20);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rmf_rst_req", 32'(mem_req), 32'h0);
            chk("rmf_rst_addr", mem_addr, 32'h0);
            chk("rmf_rst_vld", 32'(vld), 32'h0);
            for (int k = 0; k < 3; k++) chk($sformatf("rmf_rst_data%0d", k), data[k], 32'h0);
            @(posedge clk);
        end
        #1 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) chk("rmf_post_addr", mem_addr, 32'h10);
            chk($sformatf("rmf_post_vld_c%0d", c), 32'(vld), (c == 3) ? 32'h1 : 32'h0);
            @(posedge clk);
        end

        // Fairness and stability at MEM_LAT=1.
        do_reset(3'b000, 3'b111);
        mbusy = '0;
        prev  = data2;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            nv = $countones(vld2);
            chk("fair_one_vld", 32'(nv <= 1), 32'h1);
            if (mem_req2) begin
                id = int'(mem_addr2 >> 8) - 1;
                if (id >= 0 && id < 3) begin
                    chk("fair_issue_not_busy", 32'(mbusy[id]), 32'h0);
                end else begin
                    chk("fair_issue_addr_known", mem_addr2, 32'h100);
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (vld2[k]) begin
                    cnt[k]++;
                    chk("fair_data", data2[k], addr2[k] ^ K);
                    mbusy[k] = 1'b0;
                end else begin
                    chk("fair_data_hold", data2[k], prev[k]);
                end
            end
            if (mem_req2 && id >= 0 && id < 3) mbusy[id] = 1'b1;
            prev = data2;
            @(posedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fair_count%0d", k), 32'(cnt[k] >= 99 && cnt[k] <= 101), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
